// File: rtl/inst_axi_bridge.sv
// Instruction-side bridge: SRAM-like fetch requests in, single-beat AXI4 reads out.
// Each accepted fetch becomes one AR transfer. Reads are tracked by an outstanding
// counter, and R data is returned to the fetch stage in order, combinationally.
module inst_axi_bridge #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [3:0]  ARID_VAL        = 4'd0
) (
   input  logic        clk,
   input  logic        resetn,
   // fetch side
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // AXI read address
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI read data
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        bus_err
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_e;

   ar_state_e     state_q;
   logic          arvalid_q;
   logic [31:0]   ar_addr_q;
   logic [1:0]    ar_size_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bus_err_q;
   logic          addr_ok;
   logic          r_hs;

   // Write-side and ordering fields are never used: the port is read-only and in order.
   logic unused_ok;
   assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};

   // Accept only when no AR is pending and a tracking slot is free; gated by
   // reset so the fetch stage never sees an accept while the bridge is held.
   assign addr_ok = resetn & inst_sram_req & (state_q == AR_IDLE) &
                    (cnt_q < CW'(MAX_OUTSTANDING));
   assign rready  = (cnt_q != '0);
   assign r_hs    = rvalid & rready;

   assign inst_sram_addr_ok = addr_ok;
   assign inst_sram_data_ok = r_hs;
   assign inst_sram_rdata   = rdata;

   assign arid    = ARID_VAL;
   assign araddr  = ar_addr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, ar_size_q};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = arvalid_q;
   assign bus_err = bus_err_q;

   // AR FSM: latch the request, hold ARVALID/ARADDR until the slave takes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= AR_IDLE;
         arvalid_q <= 1'b0;
         ar_addr_q <= '0;
         ar_size_q <= '0;
      end else begin
         case (state_q)
            AR_IDLE: if (addr_ok) begin
               state_q   <= AR_BUSY;
               arvalid_q <= 1'b1;
               ar_addr_q <= inst_sram_addr;
               ar_size_q <= inst_sram_size;
            end
            AR_BUSY: if (arready) begin
               state_q   <= AR_IDLE;
               arvalid_q <= 1'b0;
            end
            default: begin
               state_q   <= AR_IDLE;
               arvalid_q <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding count: accept adds one, R handshake retires one, both cancel.
   always_comb begin
      cnt_d = cnt_q;
      if (addr_ok && !r_hs)      cnt_d = cnt_q + CW'(1);
      else if (!addr_ok && r_hs) cnt_d = cnt_q - CW'(1);
   end

   // Counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   // Sticky error flag on any non-OKAY response that is actually consumed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                    bus_err_q <= 1'b0;
      else if (r_hs && rresp != 2'b00) bus_err_q <= 1'b1;
   end

endmodule
